// File: rtl/lut_layer_stream.sv
// LogicNets-style layer of runtime-reloadable truth-table neurons, 1-cycle lookup, valid/ready both sides.
// Optional LUT_LAYER_CFG_CHECKSUM_EN adds cfg_checksum (XOR of the words accepted in the latest load).
module lut_layer_stream #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned FAN_IN    = 6,
  parameter int unsigned OUT_BITS  = 1,
  parameter int unsigned CFG_W     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_NEURONS*FAN_IN-1:0]     in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]   out_data,
  input  logic                            cfg_start,
  input  logic                            cfg_valid,
  input  logic [CFG_W-1:0]                cfg_data,
  output logic                            cfg_ready,
  output logic                            cfg_done,
  output logic                            busy
`ifdef LUT_LAYER_CFG_CHECKSUM_EN
  ,
  output logic [CFG_W-1:0]                cfg_checksum
`endif
);

  localparam int unsigned TBL_BITS = (1 << FAN_IN) * OUT_BITS;
  localparam int unsigned WPN      = (TBL_BITS + CFG_W - 1) / CFG_W;
  localparam int unsigned PAD_BITS = WPN * CFG_W;
  localparam int unsigned NW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned WW       = (WPN > 1) ? $clog2(WPN) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(N_NEURONS - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WPN - 1);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t                          state;
  logic [TBL_BITS-1:0]             tbl [N_NEURONS];
  logic [NW-1:0]                   nsel;
  logic [WW-1:0]                   wsel;
  logic [N_NEURONS*OUT_BITS-1:0]   lookup;
  logic [PAD_BITS-1:0]             padded;
  logic [TBL_BITS-1:0]             merged;
  logic                            accept;
  logic                            cfg_we;
  logic                            enter_load;

  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign cfg_ready = (state == LOAD);
  assign busy      = (state != RUN);
  assign accept    = in_valid && in_ready;
  assign cfg_we    = cfg_ready && cfg_valid;
  assign enter_load = ((state == RUN) && cfg_start && (!out_valid || out_ready)) ||
                      ((state == DRAIN) && out_valid && out_ready);

  always_comb begin
    lookup = '0;
    for (int unsigned n = 0; n < N_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] =
        tbl[n][int'(in_data[n*FAN_IN +: FAN_IN]) * OUT_BITS +: OUT_BITS];
    end
  end

  // The word counter is kept as (neuron, word-in-neuron) so no divider is needed;
  // a word landing partly past TBL_BITS is merged in a padded copy and truncated.
  always_comb begin
    padded = '0;
    padded[TBL_BITS-1:0] = tbl[nsel];
    padded[int'(wsel) * CFG_W +: CFG_W] = cfg_data;
    merged = padded[TBL_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_done  <= 1'b0;
      nsel      <= '0;
      wsel      <= '0;
      for (int unsigned n = 0; n < N_NEURONS; n++) tbl[n] <= '0;
    end else begin
      cfg_done <= 1'b0;
      if (accept) begin
        out_data  <= lookup;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (cfg_start) state <= (!out_valid || out_ready) ? LOAD : DRAIN;
        end
        DRAIN: begin
          if (out_valid && out_ready) state <= LOAD;
        end
        LOAD: begin
          if (cfg_we) begin
            tbl[nsel] <= merged;
            if (wsel == W_LAST) begin
              wsel <= '0;
              if (nsel == N_LAST) begin
                nsel     <= '0;
                cfg_done <= 1'b1;
                state    <= RUN;
              end else begin
                nsel <= nsel + 1'b1;
              end
            end else begin
              wsel <= wsel + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef LUT_LAYER_CFG_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cfg_checksum <= '0;
    else if (enter_load) cfg_checksum <= '0;
    else if (cfg_we)     cfg_checksum <= cfg_checksum ^ cfg_data;
  end
`else
  // enter_load only feeds the checksum; keep it referenced in the default build.
  logic unused_enter_load;
  assign unused_enter_load = enter_load;
`endif

endmodule

// File: doc/lut_layer_stream.md
Name: lut_layer_stream

Overview:
- Parametrised, registered LogicNets layer: N_NEURONS truth-table neurons, each with FAN_IN input bits and OUT_BITS output bits, evaluated in parallel on a streamed input vector.
- Truth tables live in registers and are reloaded at runtime through a word-serial config port, so one netlist serves retrained models.
- Sits between quantised-feature stages with valid/ready handshakes on both sides.

Parameters:
- N_NEURONS, 8, number of neurons in the layer.
- FAN_IN, 6, input bits per neuron; table depth is 2^FAN_IN entries.
- OUT_BITS, 1, output bits per table entry.
- CFG_W, 32, config word width.
- Derived, not overridable: TBL_BITS = 2^FAN_IN*OUT_BITS; WPN = ceil(TBL_BITS/CFG_W), words per neuron; NWORDS = N_NEURONS*WPN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts in_data.
- in_data  in  N_NEURONS*FAN_IN  neuron n address = in_data[n*FAN_IN +: FAN_IN].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  N_NEURONS*OUT_BITS  neuron n result at [n*OUT_BITS +: OUT_BITS].
- cfg_start  in  1  single-cycle pulse requesting a full table reload.
- cfg_valid  in  1  cfg_data holds the next config word.
- cfg_data  in  CFG_W  config word.
- cfg_ready  out  1  high only in LOAD.
- cfg_done  out  1  one-cycle pulse after the last word is written.
- busy  out  1  state != RUN.

Behaviour:
- Reset values:
  - all table bits 0;
  - state RUN;
  - out_valid 0, out_data 0, cfg_done 0, word counter 0.
- Lookup, RUN state:
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready, out_data takes table_n[addr_n*OUT_BITS +: OUT_BITS] for every n, and out_valid is set.
  - Latency is exactly 1 cycle.
  - Back-to-back transfers at full rate.
  - When out_valid && out_ready and there is no new input, out_valid clears.
  - out_data holds its value while out_valid && !out_ready.
- State machine, states RUN, DRAIN, LOAD:
  - RUN + cfg_start: go to LOAD if out_valid is 0, or if out_valid && out_ready this cycle; otherwise go to DRAIN. in_ready is 0 from the cycle after cfg_start. An input accepted in the cfg_start cycle still completes with the old tables.
  - DRAIN: in_ready = 0. Go to LOAD on the cycle out_valid && out_ready.
  - LOAD: in_ready = 0, cfg_ready = 1.
    - Each cfg_valid writes word k = counter to neuron k/WPN, bits [(k%WPN)*CFG_W +: CFG_W] of its table.
    - Bits beyond TBL_BITS are discarded.
    - The counter increments per word.
    - On word NWORDS-1: counter clears to 0, cfg_done pulses the next cycle, and the state returns to RUN.
    - The first lookup using the new tables is the input accepted in the first RUN cycle.
  - cfg_start in DRAIN or LOAD is ignored.
  - cfg_valid outside LOAD is ignored.
- Partial load: tables are written in place, so the words already written stay in effect. There is no abort path; only reset leaves LOAD early.
- Async reset mid-LOAD or mid-DRAIN: immediate return to the reset state, with tables cleared to 0.
- busy = 1 in DRAIN and LOAD.

Optional Feature:
- Macro: LUT_LAYER_CFG_CHECKSUM_EN.
- When defined:
  - Adds output cfg_checksum [CFG_W-1:0].
  - Cleared on reset and on entry to LOAD.
  - XORed with each accepted cfg_data word.
  - Stable from the cfg_done pulse until the next LOAD.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_data=48'h0 with out_ready=1 -> out_valid one cycle later, out_data=8'h00; after reset in_ready=1, cfg_ready=0, busy=0.
- Load all 16 words = 32'hFFFF_FFFF except neuron 3, word 1 = 32'h0000_0000; send in_data with neuron 3 address 6'd40 and all others 6'd0 -> out_data=8'hF7; cfg_done pulses exactly once, one cycle after word 15.
- Load neuron 0 table = 64'hC0C0_C0C0_3F3F_3F3F (words 32'h3F3F_3F3F then 32'hC0C0_C0C0), all other words 0; sweep neuron 0 address 0..63 -> bit 0 equals table bit [addr].
- Stream 10 vectors with out_ready toggling 1,0,0,1 -> no loss, no duplication, order preserved, out_data stable during stalls.
- Assert cfg_start while out_valid=1 and out_ready=0 for 3 cycles -> DRAIN held, in_ready=0; LOAD entered after out_ready rises; cfg_valid before that is ignored.
- Deassert rst_n after 5 of 16 config words -> state RUN, tables 0, out_valid 0, busy 0; with CHECKSUM_EN, checksum after a full load = XOR of the 16 words.
